// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 8:1 mux scan controller.
package mux_scan_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int SNAP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;
endpackage

// File: rtl/settle_timer.sv
// Counts settle cycles while enabled; expired flags the last settle cycle.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = 8;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clear) cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + 1'b1;
  end

  assign expired = (cnt_q == CW'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 8:1 mux: walks select 0..7, samples muxout into a snapshot.
// Optional MUX_SCAN_CHANGE_EN adds a 'changed' pulse when a snapshot differs from the last one.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [SEL_W-1:0]  manual_sel,
  input  logic              muxout,
  output logic [SEL_W-1:0]  select,
  output logic              busy,
  output logic [SNAP_W-1:0] snapshot,
  output logic              snap_valid,
  output logic              changed
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE_CYCLES must be in 1..255");
  end

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic                busy_q;
  logic [SNAP_W-2:0]   shadow_q;
  logic [SNAP_W-1:0]   snap_q;
  logic                vld_q;
  logic                tmr_expired;
  logic                last_sample;
  logic [SNAP_W-1:0]   snap_new;

  // Timer runs only in SETTLE and is held at zero otherwise, so every channel starts fresh.
  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != ST_SETTLE),
    .en      (state_q == ST_SETTLE),
    .expired (tmr_expired)
  );

  assign last_sample = (state_q == ST_SAMPLE) && (sel_q == SEL_W'(NUM_CH - 1));
  assign snap_new    = {muxout, shadow_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      shadow_q <= '0;
      snap_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SETTLE;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            sel_q <= manual_sel;
          end
        end
        ST_SETTLE: begin
          if (tmr_expired) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (!last_sample) begin
            shadow_q[sel_q] <= muxout;
            sel_q           <= sel_q + 1'b1;
            state_q         <= ST_SETTLE;
          end else begin
            // Channel 7 goes straight into the snapshot; no need to park it in the shadow.
            snap_q <= snap_new;
            vld_q  <= 1'b1;
            if (continuous) begin
              sel_q   <= '0;
              state_q <= ST_SETTLE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MUX_SCAN_CHANGE_EN
  logic [SNAP_W-1:0] prev_q;
  logic              chg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (last_sample) begin
        chg_q  <= (snap_new != prev_q);
        prev_q <= snap_new;
      end
    end
  end

  assign changed = chg_q;
`else
  assign changed = 1'b0;
`endif

  assign select     = sel_q;
  assign busy       = busy_q;
  assign snapshot   = snap_q;
  assign snap_valid = vld_q;
endmodule
